dfr_axil_cfg_slave: RTL and testbench

AXI4-Lite responder that terminates the host's configuration/data traffic for the hybrid DFR core. Holds the control, debug and sample/step count registers, and forwards a 256-word window at 0x0100 to the memory bank chosen by CTRL[5:4]: input, reservoir-out, weight or DFR-out. Sits between the PS/host AXI interconnect and the DFR datapath controller, and supplies the `start` pulse and `busy` readback.

---
 rtl/dfr_axil_cfg_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_dfr_axil_cfg_slave.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfr_axil_cfg_slave.sv
// AXI4-Lite slave for the DFR core: CTRL/DEBUG/count registers plus a 256-word memory window.
// Optional macro DFR_AXIL_WSTRB_EN enables per-byte write strobes (default: full-word writes).
module dfr_axil_cfg_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 16,
  parameter int unsigned MEM_ADDR_WIDTH     = 8
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic                              busy,
  output logic                              start,
  output logic [1:0]                        mem_sel,
  output logic [MEM_ADDR_WIDTH-1:0]         mem_addr,
  output logic [31:0]                       mem_wdata,
  output logic                              mem_we,
  output logic                              mem_re,
  input  logic [31:0]                       mem_rdata,
  output logic [31:0]                       num_init_samples,
  output logic [31:0]                       num_train_samples,
  output logic [31:0]                       num_test_samples,
  output logic [31:0]                       num_steps_per_sample,
  output logic [31:0]                       num_init_steps,
  output logic [31:0]                       num_train_steps,
  output logic [31:0]                       num_test_steps
);

  localparam int unsigned NUM_CNT     = 7;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WACK, ST_WRESP, ST_RACK, ST_RWAIT, ST_RDATA
  } state_t;

  state_t                          state;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]                     wdata_q;
  logic [31:2]                     ctrl_q;
  logic [31:0]                     debug_q;
  logic [31:0]                     cnt_q [NUM_CNT];

  logic [31:0]                     reg_rdata_c;
  logic [31:0]                     wmask_c;
  logic [31:0]                     merged_c;
  logic                            mem_wr_ok_c;

`ifdef DFR_AXIL_WSTRB_EN
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb_q;
`else
  logic                            unused_wstrb;
  assign unused_wstrb = ^S_AXI_WSTRB;
`endif

  function automatic logic in_window(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
    return a[15:8] == 8'h01;
  endfunction

  function automatic logic in_regs(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
    return (a[15:8] == 8'h00) && (a[1:0] == 2'b00) && (a[7:2] <= 6'd8);
  endfunction

  assign mem_sel              = ctrl_q[5:4];
  assign num_init_samples     = cnt_q[0];
  assign num_train_samples    = cnt_q[1];
  assign num_test_samples     = cnt_q[2];
  assign num_steps_per_sample = cnt_q[3];
  assign num_init_steps       = cnt_q[4];
  assign num_train_steps      = cnt_q[5];
  assign num_test_steps       = cnt_q[6];

  // Register readback for the latched address; also the base for masked writes.
  always_comb begin
    reg_rdata_c = '0;
    case (addr_q[7:2])
      6'd0:    reg_rdata_c = {ctrl_q, busy, 1'b0};
      6'd1:    reg_rdata_c = debug_q;
      default: begin
        for (int i = 0; i < NUM_CNT; i++) begin
          if (addr_q[7:2] == 6'(i + 2)) reg_rdata_c = cnt_q[i];
        end
      end
    endcase
  end

  always_comb begin
    wmask_c     = '1;
    mem_wr_ok_c = 1'b1;
`ifdef DFR_AXIL_WSTRB_EN
    for (int b = 0; b < 4; b++) wmask_c[8*b +: 8] = {8{wstrb_q[b]}};
    mem_wr_ok_c = (wstrb_q == 4'hF);
`endif
    merged_c = (reg_rdata_c & ~wmask_c) | (wdata_q & wmask_c);
  end

  // Single shared transaction FSM; one AXI transaction in flight at a time.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state         <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      ctrl_q        <= '0;
      debug_q       <= '0;
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
`ifdef DFR_AXIL_WSTRB_EN
      wstrb_q       <= '0;
`endif
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= '0;
      start         <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_we        <= 1'b0;
      mem_re        <= 1'b0;
    end else begin
      start  <= 1'b0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            addr_q        <= S_AXI_AWADDR;
            wdata_q       <= S_AXI_WDATA;
`ifdef DFR_AXIL_WSTRB_EN
            wstrb_q       <= S_AXI_WSTRB;
`endif
            mem_addr      <= S_AXI_AWADDR[MEM_ADDR_WIDTH-1:0];
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            state         <= ST_WACK;
          end else if (S_AXI_ARVALID) begin
            // mem_re lands in the AR handshake cycle so mem_rdata is ready in RWAIT.
            addr_q        <= S_AXI_ARADDR;
            mem_addr      <= S_AXI_ARADDR[MEM_ADDR_WIDTH-1:0];
            mem_re        <= in_window(S_AXI_ARADDR);
            S_AXI_ARREADY <= 1'b1;
            state         <= ST_RACK;
          end
        end
        ST_WACK: begin
          S_AXI_AWREADY <= 1'b0;
          S_AXI_WREADY  <= 1'b0;
          S_AXI_BVALID  <= 1'b1;
          S_AXI_BRESP   <= (in_window(addr_q) || in_regs(addr_q)) ? RESP_OKAY : RESP_SLVERR;
          if (in_window(addr_q)) begin
            mem_wdata <= wdata_q;
            mem_we    <= mem_wr_ok_c;
          end else if (in_regs(addr_q)) begin
            case (addr_q[7:2])
              6'd0: begin
                ctrl_q <= merged_c[31:2];
                start  <= wdata_q[0] & wmask_c[0] & ~busy;
              end
              6'd1:    debug_q <= merged_c;
              default: begin
                for (int i = 0; i < NUM_CNT; i++) begin
                  if (addr_q[7:2] == 6'(i + 2)) cnt_q[i] <= merged_c;
                end
              end
            endcase
          end
          state <= ST_WRESP;
        end
        ST_WRESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        ST_RACK: begin
          S_AXI_ARREADY <= 1'b0;
          state         <= ST_RWAIT;
        end
        ST_RWAIT: begin
          if (in_window(addr_q)) begin
            S_AXI_RDATA <= mem_rdata;
            S_AXI_RRESP <= RESP_OKAY;
          end else if (in_regs(addr_q)) begin
            S_AXI_RDATA <= reg_rdata_c;
            S_AXI_RRESP <= RESP_OKAY;
          end else begin
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_SLVERR;
          end
          S_AXI_RVALID <= 1'b1;
          state        <= ST_RDATA;
        end
        ST_RDATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dfr_axil_cfg_slave.sv
// Self-checking bench for dfr_axil_cfg_slave: directed scenarios plus randomized traffic
// checked against a register/memory reference model.
module tb_dfr_axil_cfg_slave;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        busy, start, mem_we, mem_re;
  logic [1:0]  mem_sel;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] cnt_out [7];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dfr_axil_cfg_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .busy(busy), .start(start), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .num_init_samples(cnt_out[0]), .num_train_samples(cnt_out[1]),
    .num_test_samples(cnt_out[2]), .num_steps_per_sample(cnt_out[3]),
    .num_init_steps(cnt_out[4]), .num_train_steps(cnt_out[5]), .num_test_steps(cnt_out[6])
  );

  // External memory banks: written by mem_we, read data one cycle after mem_re.
  function automatic logic [31:0] ram_seed(input int b, input int i);
    return 32'(b) * 32'h1000_0000 + 32'(i) * 32'd3 + 32'd1;
  endfunction

  logic [31:0] ram [4][256];
  bit          ram_ready;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int b = 0; b < 4; b++)
        for (int i = 0; i < 256; i++) ram[b][i] <= ram_seed(b, i);
      ram_ready <= 1'b1;
    end else if (mem_we) begin
      ram[mem_sel][mem_addr] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= ram[mem_sel][mem_addr];
  end

  int          start_cnt = 0, we_cnt = 0, re_cnt = 0;
  logic [1:0]  last_sel;
  logic [7:0]  last_addr;
  logic [31:0] last_wdata;
  always @(negedge clk) begin
    if (start) start_cnt++;
    if (mem_re) re_cnt++;
    if (mem_we) begin
      we_cnt++;
      last_sel   = mem_sel;
      last_addr  = mem_addr;
      last_wdata = mem_wdata;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: exp_reg[0]=CTRL (bits 1:0 stored 0), [1]=DEBUG, [2..8]=counts.
  logic [31:0] exp_reg [9];
  logic [31:0] exp_mem [4][256];

  function automatic int reg_idx(input logic [15:0] a);
    if (a <= 16'h0020 && a % 4 == 0) return int'(a) / 4;
    return -1;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [31:0] d,
                             output logic [1:0] eresp, output int estart, output int ewe);
    logic [31:0] m;
    bit          full;
    int          idx;
    m    = '1;
    full = 1'b1;
`ifdef DFR_AXIL_WSTRB_EN
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{wstrb[b]}};
    full = (wstrb == 4'hF);
`endif
    estart = 0;
    ewe    = 0;
    eresp  = 2'b10;
    idx    = reg_idx(a);
    if (a[15:8] == 8'h01) begin
      eresp = 2'b00;
      if (full) begin
        exp_mem[exp_reg[0][5:4]][a[7:0]] = d;
        ewe = 1;
      end
    end else if (idx >= 0) begin
      eresp = 2'b00;
      exp_reg[idx] = (exp_reg[idx] & ~m) | (d & m);
      if (idx == 0) begin
        exp_reg[0][1:0] = 2'b00;
        estart = (d[0] && m[0] && !busy) ? 1 : 0;
      end
    end
  endtask

  task automatic model_read(input logic [15:0] a, output logic [31:0] ed, output logic [1:0] eresp);
    int idx;
    idx   = reg_idx(a);
    ed    = '0;
    eresp = 2'b10;
    if (a[15:8] == 8'h01) begin
      ed    = exp_mem[exp_reg[0][5:4]][a[7:0]];
      eresp = 2'b00;
    end else if (idx >= 0) begin
      eresp = 2'b00;
      ed    = (idx == 0) ? {exp_reg[0][31:2], busy, 1'b0} : exp_reg[idx];
    end
  endtask

  task automatic do_reset();
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = 4'hF; busy = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 9; i++) exp_reg[i] = '0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int aw_lat, output int b_lat);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(awready && wready) && n < TMO);
    aw_lat = n;
    n = 0;
    do begin @(posedge clk); #1; n++; awvalid = 0; wvalid = 0; end while (!bvalid && n < TMO);
    b_lat = n;
    resp  = bresp;
    @(posedge clk); #1;
    bready = 0;
    if (aw_lat >= TMO || b_lat >= TMO) begin
      checks++; errors++;
      $display("FAIL write_timeout addr=%h aw_lat=%0d b_lat=%0d limit=%0d", a, aw_lat, b_lat, TMO);
    end
  endtask

  task automatic do_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output int ar_lat, output int r_lat);
    int n;
    araddr = a; arvalid = 1; rready = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!arready && n < TMO);
    ar_lat = n;
    n = 0;
    do begin @(posedge clk); #1; n++; arvalid = 0; end while (!rvalid && n < TMO);
    r_lat = n;
    d     = rdata;
    resp  = rresp;
    @(posedge clk); #1;
    rready = 0;
    if (ar_lat >= TMO || r_lat >= TMO) begin
      checks++; errors++;
      $display("FAIL read_timeout addr=%h ar_lat=%0d r_lat=%0d limit=%0d", a, ar_lat, r_lat, TMO);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_handshake got=%b want=00000", {awready, wready, bvalid, arready, rvalid});
    end
    checks++;
    if ({start, mem_we, mem_re, mem_sel} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes got=%b want=00000", {start, mem_we, mem_re, mem_sel});
    end
    checks++;
    if ({bresp, rresp, rdata, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data bresp=%b rresp=%b rdata=%h mem_addr=%h mem_wdata=%h want all 0",
               bresp, rresp, rdata, mem_addr, mem_wdata);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (cnt_out[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_count[%0d] got=%h want=0", i, cnt_out[i]);
      end
    end
  endtask

  task automatic test_ctrl_write();
    logic [1:0] resp, eresp;
    logic [31:0] d;
    int al, bl, es, ew, s0;
    busy = 0;
    s0 = start_cnt;
    do_write(16'h0000, 32'hDEAD_BEEE, 4'hF, resp, al, bl);
    model_write(16'h0000, 32'hDEAD_BEEE, eresp, es, ew);
    checks++;
    if (resp !== 2'b00 || al != 1 || bl != 1) begin
      errors++;
      $display("FAIL ctrl_write_timing resp=%b aw_lat=%0d b_lat=%0d want 00/1/1", resp, al, bl);
    end
    checks++;
    if (start_cnt != s0) begin
      errors++;
      $display("FAIL ctrl_no_start pulses=%0d want=0", start_cnt - s0);
    end
    checks++;
    if (mem_sel !== 2'b10) begin
      errors++;
      $display("FAIL ctrl_mem_sel got=%b want=10", mem_sel);
    end
    do_read(16'h0000, d, resp, al, bl);
    checks++;
    if (d !== 32'hDEAD_BEEC || resp !== 2'b00) begin
      errors++;
      $display("FAIL ctrl_readback got=%h/%b want=deadbeec/00", d, resp);
    end
    checks++;
    if (al != 1 || bl != 2) begin
      errors++;
      $display("FAIL read_timing ar_lat=%0d r_lat=%0d want 1/2", al, bl);
    end
  endtask

  task automatic test_mem_window();
    logic [1:0] resp, eresp;
    logic [31:0] d, ed;
    int al, bl, es, ew, w0, r0;
    do_write(16'h0000, 32'h20, 4'hF, resp, al, bl);
    model_write(16'h0000, 32'h20, eresp, es, ew);
    w0 = we_cnt;
    do_write(16'h0105, 32'd7, 4'hF, resp, al, bl);
    model_write(16'h0105, 32'd7, eresp, es, ew);
    checks++;
    if (we_cnt - w0 != 1 || last_sel !== 2'd2 || last_addr !== 8'd5 || last_wdata !== 32'd7) begin
      errors++;
      $display("FAIL mem_write we=%0d sel=%0d addr=%0d data=%h want 1/2/5/7",
               we_cnt - w0, last_sel, last_addr, last_wdata);
    end
    checks++;
    if (resp !== 2'b00) begin
      errors++;
      $display("FAIL mem_write_resp got=%b want=00", resp);
    end
    r0 = re_cnt;
    do_read(16'h0105, d, resp, al, bl);
    checks++;
    if (d !== 32'd7 || resp !== 2'b00 || re_cnt - r0 != 1 || bl != 2) begin
      errors++;
      $display("FAIL mem_read data=%h resp=%b re=%0d r_lat=%0d want 7/00/1/2", d, resp, re_cnt - r0, bl);
    end
    r0 = re_cnt;
    do_read(16'h01FF, d, resp, al, bl);
    model_read(16'h01FF, ed, eresp);
    checks++;
    if (d !== ed || resp !== eresp || bl != 2) begin
      errors++;
      $display("FAIL mem_read_top data=%h resp=%b r_lat=%0d want %h/%b/2", d, resp, bl, ed, eresp);
    end
    do_read(16'h0004, d, resp, al, bl);
    checks++;
    if (re_cnt - r0 != 1) begin
      errors++;
      $display("FAIL reg_read_no_mem_re mem_re_pulses=%0d want=1", re_cnt - r0);
    end
  endtask

  task automatic test_start();
    logic [1:0] resp, eresp;
    logic [31:0] d;
    int al, bl, es, ew, s0;
    busy = 0;
    s0 = start_cnt;
    do_write(16'h0000, 32'h1, 4'hF, resp, al, bl);
    model_write(16'h0000, 32'h1, eresp, es, ew);
    checks++;
    if (start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL start_pulse pulses=%0d want=1", start_cnt - s0);
    end
    busy = 1;
    s0 = start_cnt;
    do_write(16'h0000, 32'h1, 4'hF, resp, al, bl);
    model_write(16'h0000, 32'h1, eresp, es, ew);
    checks++;
    if (start_cnt != s0) begin
      errors++;
      $display("FAIL start_while_busy pulses=%0d want=0", start_cnt - s0);
    end
    do_read(16'h0000, d, resp, al, bl);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL ctrl_busy_readback got=%h want=00000002", d);
    end
    busy = 0;
  endtask

  task automatic test_counts();
    logic [1:0] resp, eresp;
    logic [31:0] d;
    int al, bl, es, ew, w0;
    do_write(16'h0020, 32'd50, 4'hF, resp, al, bl);
    model_write(16'h0020, 32'd50, eresp, es, ew);
    do_read(16'h0020, d, resp, al, bl);
    checks++;
    if (d !== 32'd50 || resp !== 2'b00 || cnt_out[6] !== 32'd50) begin
      errors++;
      $display("FAIL test_steps got=%0d resp=%b port=%0d want 50/00/50", d, resp, cnt_out[6]);
    end
    do_read(16'h0024, d, resp, al, bl);
    checks++;
    if (d !== 32'h0 || resp !== 2'b10) begin
      errors++;
      $display("FAIL unmapped_read got=%h/%b want=0/10", d, resp);
    end
    w0 = we_cnt;
    do_write(16'h0200, 32'hFFFF, 4'hF, resp, al, bl);
    model_write(16'h0200, 32'hFFFF, eresp, es, ew);
    checks++;
    if (resp !== 2'b10 || we_cnt != w0) begin
      errors++;
      $display("FAIL unmapped_write resp=%b we=%0d want 10/0", resp, we_cnt - w0);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] eresp;
    logic [31:0] ed;
    int n, es, ew;
    awaddr = 16'h0004; wdata = 32'hA5A5_0001; wstrb = 4'hF;
    araddr = 16'h0004;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 0; rready = 0;
    model_write(16'h0004, 32'hA5A5_0001, eresp, es, ew);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(awready && wready) && n < TMO);
    checks++;
    if (n != 1 || arready !== 1'b0) begin
      errors++;
      $display("FAIL collision_write_first aw_lat=%0d arready=%b want 1/0", n, arready);
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bvalid !== 1'b1 || arready !== 1'b0) begin
        errors++;
        $display("FAIL bready_stall cycle=%0d bvalid=%b arready=%b want 1/0", i, bvalid, arready);
      end
      @(posedge clk); #1;
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL bvalid_drop got=%b want=0", bvalid);
    end
    n = 0;
    while (!arready && n < TMO) begin @(posedge clk); #1; n++; end
    rready = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; arvalid = 0; end while (!rvalid && n < TMO);
    model_read(16'h0004, ed, eresp);
    checks++;
    if (rdata !== ed || rresp !== eresp || n >= TMO) begin
      errors++;
      $display("FAIL collision_read got=%h/%b want=%h/%b", rdata, rresp, ed, eresp);
    end
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic test_random();
    logic [1:0] resp, eresp;
    logic [31:0] d, ed;
    logic [15:0] a;
    int al, bl, es, ew, s0, w0, r;
    for (int t = 0; t < 80; t++) begin
      busy = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r <= 5)      a = 16'(4 * $urandom_range(0, 8));
      else if (r <= 7) a = 16'h0100 | 16'($urandom_range(0, 255));
      else if (r == 8) a = 16'(4 * $urandom_range(9, 63));
      else             a = 16'($urandom_range(2, 255) << 8) | 16'($urandom_range(0, 255));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        s0 = start_cnt;
        w0 = we_cnt;
        do_write(a, d, 4'($urandom_range(0, 15)), resp, al, bl);
        model_write(a, d, eresp, es, ew);
        checks++;
        if (resp !== eresp || start_cnt - s0 != es || we_cnt - w0 != ew) begin
          errors++;
          $display("FAIL rand_write addr=%h resp=%b start=%0d we=%0d want %b/%0d/%0d",
                   a, resp, start_cnt - s0, we_cnt - w0, eresp, es, ew);
        end
      end else begin
        do_read(a, d, resp, al, bl);
        model_read(a, ed, eresp);
        checks++;
        if (d !== ed || resp !== eresp || bl != 2) begin
          errors++;
          $display("FAIL rand_read addr=%h got=%h/%b r_lat=%0d want=%h/%b/2", a, d, resp, bl, ed, eresp);
        end
      end
    end
    busy = 0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (cnt_out[i] !== exp_reg[i + 2]) begin
        errors++;
        $display("FAIL rand_count_port[%0d] got=%h want=%h", i, cnt_out[i], exp_reg[i + 2]);
      end
    end
    checks++;
    if (mem_sel !== exp_reg[0][5:4]) begin
      errors++;
      $display("FAIL rand_mem_sel got=%b want=%b", mem_sel, exp_reg[0][5:4]);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp, eresp;
    logic [31:0] d;
    int al, bl, es, ew, s0, n;
    busy = 0;
    do_write(16'h0004, 32'h1234_5678, 4'hF, resp, al, bl);
    model_write(16'h0004, 32'h1234_5678, eresp, es, ew);
    do_write(16'h0008, 32'h99, 4'hF, resp, al, bl);
    model_write(16'h0008, 32'h99, eresp, es, ew);
    s0 = start_cnt;
    awaddr = 16'h0000; wdata = 32'h31; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(awready && wready) && n < TMO);
    rst = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b0 || n >= TMO) begin
      errors++;
      $display("FAIL reset_abort bvalid=%b awready=%b want 0/0", bvalid, awready);
    end
    @(posedge clk); #1;
    rst = 0;
    bready = 0;
    for (int i = 0; i < 9; i++) exp_reg[i] = '0;
    @(posedge clk); #1;
    checks++;
    if (bvalid !== 1'b0 || start_cnt != s0 || mem_sel !== 2'b00) begin
      errors++;
      $display("FAIL reset_no_commit bvalid=%b start=%0d mem_sel=%b want 0/0/00",
               bvalid, start_cnt - s0, mem_sel);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (cnt_out[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_mid_count[%0d] got=%h want=0", i, cnt_out[i]);
      end
    end
    do_read(16'h0004, d, resp, al, bl);
    checks++;
    if (d !== 32'h0 || resp !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_debug got=%h/%b want=0/00", d, resp);
    end
  endtask

  initial begin
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 256; i++) exp_mem[b][i] = ram_seed(b, i);
    test_reset();
    test_ctrl_write();
    test_mem_window();
    test_start();
    test_counts();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
